// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_stage_pkg
// Description : Shared widths, bus layouts and reset constants for the fetch
//               stage and its fetch->decode / decode->fetch buses.
//               br_bus       = {br_stall, br_taken, br_target[31:0]}  (34 bits)
//               fs_to_ds_bus = {fs_inst[31:0], fs_pc[31:0]}          (64 bits)
// Revision    : 1.0 - initial release
// ============================================================================
package if_stage_pkg;

  localparam int          BR_BUS_WD        = 34;
  localparam int          FS_TO_DS_BUS_WD  = 64;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc00000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  // Field order of the packed structs fixes the bus bit positions (MSB first).
  typedef struct packed {
    logic        stall;   // [33] decode holds an unresolved branch
    logic        taken;   // [32]
    logic [31:0] target;  // [31:0]
  } br_bus_t;

  typedef struct packed {
    logic [31:0] inst;    // [63:32]
    logic [31:0] pc;      // [31:0]
  } fs_to_ds_t;

  // Sequential successor, 32-bit modulo (0xfffffffc wraps to 0).
  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : if_stage_if
// Description : Fetch-stage bus bundle: fetch->decode handshake, branch bus
//               from decode and the instruction SRAM port.
//               master : the fetch stage (drives fs_to_ds_*, inst_sram_* reqs)
//               slave  : decode + SRAM side (drives ds_allowin, br_bus, rdata)
// Revision    : 1.0 - initial release
// ============================================================================
interface if_stage_if;
  import if_stage_pkg::*;

  logic        ds_allowin;
  br_bus_t     br_bus;
  logic        fs_to_ds_valid;
  fs_to_ds_t   fs_to_ds_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  modport master (
    input  ds_allowin, br_bus, inst_sram_rdata,
    output fs_to_ds_valid, fs_to_ds_bus,
    output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata
  );

  modport slave (
    output ds_allowin, br_bus, inst_sram_rdata,
    input  fs_to_ds_valid, fs_to_ds_bus,
    input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata
  );

endinterface
`default_nettype wire

// File: rtl/if_inst_buf.sv
`default_nettype none
// ============================================================================
// Module      : if_inst_buf
// Description : One-entry skid register for the fetched instruction. Captures
//               the SRAM read data in the first cycle decode refuses the held
//               instruction, so the SRAM need not hold its output while the
//               fetch stage is stalled. Used only when FS_INST_BUF_EN is set.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               i_fs_valid      - fetch stage holds an instruction
//               i_ds_allowin    - decode accepts this cycle
//               i_rdata         - instruction SRAM read data
//               o_inst          - instruction presented to decode
// Revision    : 1.0 - initial release
// ============================================================================
module if_inst_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_fs_valid,
  input  logic        i_ds_allowin,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_inst
);

  logic        r_valid;
  logic [31:0] r_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_fs_valid & i_ds_allowin) begin
      r_valid <= 1'b0;                    // instruction handed to decode
    end else if (i_fs_valid & ~r_valid) begin
      r_valid <= 1'b1;                    // first stalled cycle: rdata still good
      r_data  <= i_rdata;
    end
  end

  assign o_inst = r_valid ? r_data : i_rdata;

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : MIPS fetch stage. Computes next PC (sequential, branch redirect
//               or latched pending redirect), drives the synchronous
//               instruction SRAM and hands {inst, pc} to decode over a
//               valid/allowin handshake. The delay slot is always delivered;
//               only the fetch after it is redirected.
// Ports       : clk    - clock
//               reset  - synchronous active-high reset
//               fs     - if_stage_if.master (handshake, br_bus, inst SRAM)
// Config      : FS_INST_BUF_EN - add a skid buffer for the fetched instruction
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  if_stage_if.master  fs
);

  logic        r_fs_valid;
  logic [31:0] r_fs_pc;
  logic        r_br_pending;
  logic [31:0] r_br_target;

  br_bus_t     w_br;
  logic        w_to_fs_valid;
  logic        w_fs_allowin;
  logic        w_accept;
  logic [31:0] w_nextpc;
  logic [31:0] w_fs_inst;

  assign w_br          = fs.br_bus;
  assign w_to_fs_valid = ~reset;
  // fs_ready_go is constant 1, so the stage frees up whenever decode takes.
  assign w_fs_allowin  = ~r_fs_valid | fs.ds_allowin;
  assign w_accept      = w_to_fs_valid & w_fs_allowin & ~w_br.stall;
  assign w_nextpc      = r_br_pending ? r_br_target
                       : (w_br.taken  ? w_br.target : seq_pc(r_fs_pc));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fs_valid   <= 1'b0;
      r_fs_pc      <= RESET_PC - PC_STEP;   // first nextpc lands on RESET_PC
      r_br_pending <= 1'b0;
      r_br_target  <= '0;
    end else begin
      if (w_accept) begin
        r_fs_valid   <= 1'b1;
        r_fs_pc      <= w_nextpc;
        r_br_pending <= 1'b0;
      end else if (w_fs_allowin) begin
        // Only br_stall blocks an otherwise-possible fetch: send a bubble.
        r_fs_valid   <= 1'b0;
      end
      // Redirect arrives while the delay slot cannot move: remember it for
      // the next accepted fetch.
      if (w_br.taken & ~w_br.stall & ~w_fs_allowin) begin
        r_br_pending <= 1'b1;
        r_br_target  <= w_br.target;
      end
    end
  end

`ifdef FS_INST_BUF_EN
  if_inst_buf u_inst_buf (
    .clk          (clk),
    .reset        (reset),
    .i_fs_valid   (r_fs_valid),
    .i_ds_allowin (fs.ds_allowin),
    .i_rdata      (fs.inst_sram_rdata),
    .o_inst       (w_fs_inst)
  );
`else
  // SRAM keeps its last output because en stays low while stalled.
  assign w_fs_inst = fs.inst_sram_rdata;
`endif

  assign fs.fs_to_ds_valid  = r_fs_valid;
  assign fs.fs_to_ds_bus    = '{inst: w_fs_inst, pc: r_fs_pc};
  assign fs.inst_sram_en    = w_accept;
  assign fs.inst_sram_wen   = 4'h0;
  assign fs.inst_sram_addr  = w_nextpc;
  assign fs.inst_sram_wdata = 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_stage
// Description : Self-checking bench for if_stage: directed vector table for
//               the fetch / branch / stall / reset sequences, then random
//               traffic checked against a transaction-level fetch model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [31:0] B = 32'hbfc00000;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  if_stage_if bus();

  if_stage dut (
    .clk   (clk),
    .reset (reset),
    .fs    (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hdeadbeef;
  endfunction

  // Synchronous SRAM; with the skid buffer it is free to scribble when idle.
  always @(posedge clk) begin
    if (bus.inst_sram_en) bus.inst_sram_rdata <= mem(bus.inst_sram_addr);
`ifdef FS_INST_BUF_EN
    else                  bus.inst_sram_rdata <= $urandom;
`endif
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // Fetch stream = last fetched address + 4, unless a redirect is owed.
  // The stage holds at most one instruction; it is handed on when decode
  // accepts, and a new fetch is possible if the slot is or becomes free.
  logic        m_held;      // an instruction is waiting for decode
  logic [31:0] m_last;      // address of the most recent fetch
  logic        m_owed;      // redirect recorded but not yet used
  logic [31:0] m_owed_to;
  logic        c_a, c_s, c_t, c_r;
  logic [31:0] c_tg;

  task automatic model_reset();
    m_held = 1'b0; m_last = RESET_PC_DEFAULT - 32'd4; m_owed = 1'b0; m_owed_to = '0;
  endtask

  task automatic drive(input logic a, input logic s, input logic t,
                       input logic [31:0] tg, input logic r);
    c_a = a; c_s = s; c_t = t; c_tg = tg; c_r = r;
    bus.ds_allowin = a;
    bus.br_bus     = {s, t, tg};
    reset          = r;
    #1;
  endtask

  task automatic advance();
    logic        slot_free, fetch;
    logic [31:0] want;
    slot_free = !m_held || c_a;
    fetch     = !c_r && slot_free && !c_s;
    if (m_owed)     want = m_owed_to;
    else if (c_t)   want = c_tg;
    else            want = m_last + 32'd4;
    chk("model_en", {31'd0, bus.inst_sram_en}, {31'd0, fetch});
    if (fetch) chk("model_addr", bus.inst_sram_addr, want);
    chk("model_valid", {31'd0, bus.fs_to_ds_valid}, {31'd0, m_held});
    if (m_held) begin
      chk("model_pc",   bus.fs_to_ds_bus.pc,   m_last);
      chk("model_inst", bus.fs_to_ds_bus.inst, mem(m_last));
    end
    if (c_r) model_reset();
    else begin
      if (!slot_free && c_t && !c_s) begin m_owed = 1'b1; m_owed_to = c_tg; end
      if (fetch) begin m_held = 1'b1; m_last = want; m_owed = 1'b0; end
      else if (slot_free) m_held = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        a, s, t, r;
    logic [31:0] tg;
    logic        en;
    logic [31:0] addr;
    logic        v;
    logic [31:0] pc;
  } vec_t;

  function automatic vec_t mk(input logic a, input logic s, input logic t,
                              input logic [31:0] tg, input logic r,
                              input logic en, input logic [31:0] addr,
                              input logic v, input logic [31:0] pc);
    vec_t x;
    x.a = a; x.s = s; x.t = t; x.tg = tg; x.r = r;
    x.en = en; x.addr = addr; x.v = v; x.pc = pc;
    return x;
  endfunction

  vec_t tbl[37];

  initial begin
    // sequential fetch and a taken branch with its delay slot
    tbl[0]  = mk(1,0,0,0,1,        0,0,          0,0);
    tbl[1]  = mk(1,0,0,0,0,        1,B,          0,0);
    tbl[2]  = mk(1,0,0,0,0,        1,B+4,        1,B);
    tbl[3]  = mk(1,0,0,0,0,        1,B+8,        1,B+4);
    tbl[4]  = mk(1,0,1,B+'h100,0,  1,B+'h100,    1,B+8);
    tbl[5]  = mk(1,0,0,0,0,        1,B+'h104,    1,B+'h100);
    tbl[6]  = mk(1,0,0,0,1,        0,0,          1,B+'h104);
    tbl[7]  = mk(1,0,0,0,1,        0,0,          0,0);
    // decode stall with fs_pc = B+0x10
    tbl[8]  = mk(1,0,0,0,0,        1,B,          0,0);
    tbl[9]  = mk(1,0,0,0,0,        1,B+4,        1,B);
    tbl[10] = mk(1,0,0,0,0,        1,B+8,        1,B+4);
    tbl[11] = mk(1,0,0,0,0,        1,B+'hc,      1,B+8);
    tbl[12] = mk(1,0,0,0,0,        1,B+'h10,     1,B+'hc);
    tbl[13] = mk(0,0,0,0,0,        0,0,          1,B+'h10);
    tbl[14] = mk(0,0,0,0,0,        0,0,          1,B+'h10);
    tbl[15] = mk(0,0,0,0,0,        0,0,          1,B+'h10);
    tbl[16] = mk(1,0,0,0,0,        1,B+'h14,     1,B+'h10);
    // branch taken while decode is stalled -> pending redirect
    tbl[17] = mk(0,0,1,B+'h200,0,  0,0,          1,B+'h14);
    tbl[18] = mk(0,0,0,0,0,        0,0,          1,B+'h14);
    tbl[19] = mk(1,0,0,0,0,        1,B+'h200,    1,B+'h14);
    tbl[20] = mk(1,0,0,0,0,        1,B+'h204,    1,B+'h200);
    // br_stall for two cycles, then redirect
    tbl[21] = mk(1,1,0,0,0,        0,0,          1,B+'h204);
    tbl[22] = mk(1,1,0,0,0,        0,0,          0,0);
    tbl[23] = mk(1,0,1,B+'h40,0,   1,B+'h40,     0,0);
    tbl[24] = mk(1,0,0,0,0,        1,B+'h44,     1,B+'h40);
    // reset mid-stream at fs_pc = B+0xc
    tbl[25] = mk(1,0,0,0,1,        0,0,          1,B+'h44);
    tbl[26] = mk(1,0,0,0,1,        0,0,          0,0);
    tbl[27] = mk(1,0,0,0,0,        1,B,          0,0);
    tbl[28] = mk(1,0,0,0,0,        1,B+4,        1,B);
    tbl[29] = mk(1,0,0,0,0,        1,B+8,        1,B+4);
    tbl[30] = mk(1,0,0,0,0,        1,B+'hc,      1,B+8);
    tbl[31] = mk(1,0,0,0,1,        0,0,          1,B+'hc);
    tbl[32] = mk(1,0,0,0,0,        1,B,          0,0);
    tbl[33] = mk(1,0,0,0,0,        1,B+4,        1,B);
    // 32-bit wrap of the sequential PC
    tbl[34] = mk(1,0,1,32'hfffffffc,0, 1,32'hfffffffc, 1,B+4);
    tbl[35] = mk(1,0,0,0,0,        1,32'h0,      1,32'hfffffffc);
    tbl[36] = mk(1,0,0,0,0,        1,32'h4,      1,32'h0);
  end

  initial begin
    bus.inst_sram_rdata = '0;
    drive(1, 0, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    for (int i = 0; i < 37; i++) begin
      drive(tbl[i].a, tbl[i].s, tbl[i].t, tbl[i].tg, tbl[i].r);
      chk($sformatf("vec%0d_en", i), {31'd0, bus.inst_sram_en}, {31'd0, tbl[i].en});
      if (tbl[i].en)
        chk($sformatf("vec%0d_addr", i), bus.inst_sram_addr, tbl[i].addr);
      chk($sformatf("vec%0d_valid", i), {31'd0, bus.fs_to_ds_valid}, {31'd0, tbl[i].v});
      if (tbl[i].v) begin
        chk($sformatf("vec%0d_pc", i),   bus.fs_to_ds_bus.pc,   tbl[i].pc);
        chk($sformatf("vec%0d_inst", i), bus.fs_to_ds_bus.inst, mem(tbl[i].pc));
      end
      chk($sformatf("vec%0d_wen", i), {28'd0, bus.inst_sram_wen}, 32'd0);
      chk($sformatf("vec%0d_wdata", i), bus.inst_sram_wdata, 32'd0);
      advance();
    end

    // randomized traffic against the model
    drive(1, 0, 0, 0, 1);
    advance();
    for (int n = 0; n < 3000; n++) begin
      logic a, s, t, r;
      logic [31:0] tg;
      r  = ($urandom_range(0, 99) == 0);
      a  = ($urandom_range(0, 3) != 0);
      s  = ($urandom_range(0, 5) == 0);
      t  = !s && !m_owed && ($urandom_range(0, 4) == 0);
      tg = $urandom & 32'hfffffffc;
      drive(a, s, t, tg, r);
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_stage.md
Name: if_stage

Overview:
- Fetch stage of the 5-stage MIPS pipeline, and the transmitting end of the fetch→decode interface.
- Holds the pre-IF next-PC logic and drives the synchronous instruction SRAM.
- Presents {inst, pc} to decode via the fs_to_ds valid/allowin handshake.
- Consumes the branch bus returned by decode and honours the single architectural delay slot.

Parameters:
- RESET_PC, 32'hbfc00000, address of the first instruction fetched after reset.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- ds_allowin  input  1  decode can accept a new instruction this cycle.
- br_bus  input  `BR_BUS_WD (34)  {br_stall[33], br_taken[32], br_target[31:0]}; br_stall means decode holds an unresolved branch (operands not ready).
- fs_to_ds_valid  output  1  fs_to_ds_bus carries a valid instruction.
- fs_to_ds_bus  output  `FS_TO_DS_BUS_WD (64)  {fs_inst[63:32], fs_pc[31:0]}.
- inst_sram_en  output  1  read enable.
- inst_sram_wen  output  4  always 4'h0.
- inst_sram_addr  output  32  fetch address (nextpc).
- inst_sram_wdata  output  32  always 0.
- inst_sram_rdata  input  32  read data, valid one cycle after an enabled read.

Behaviour:
- Clock and reset: one clock (clk); synchronous active-high reset (reset).
- Pre-IF:
  - to_fs_valid = ~reset.
  - seq_pc = fs_pc + 4.
  - nextpc = br_pending ? br_target_r : (br_taken ? br_target : seq_pc).
  - All arithmetic is 32-bit modulo; 0xfffffffc+4 wraps to 0.
- Reset state:
  - fs_pc = RESET_PC-4, so the first nextpc is RESET_PC.
  - fs_valid = 0, br_pending = 0, fs_to_ds_valid = 0.
  - fs_to_ds_bus is don't-care while fs_to_ds_valid = 0.
- Handshake:
  - fs_ready_go = 1.
  - fs_allowin = ~fs_valid | (fs_ready_go & ds_allowin).
  - fs_to_ds_valid = fs_valid & fs_ready_go.
- Fetch accept: when to_fs_valid & fs_allowin & ~br_stall:
  - fs_valid <= 1 and fs_pc <= nextpc.
  - inst_sram_en = 1 in that same cycle.
  - The instruction appears on inst_sram_rdata the next cycle, as fs_inst.
- br_stall gating:
  - br_stall = 1 forces inst_sram_en = 0.
  - If fs_allowin, fs_valid <= 0 (a bubble goes to decode). fs_pc is unchanged.
  - No wrong-path fetch is ever issued.
- Delay slot:
  - While the branch is in decode, fs_pc is the delay-slot PC.
  - The delay slot is always delivered to decode; only the following fetch is redirected.
- Branch pending:
  - If br_taken & ~br_stall while a fetch cannot be accepted (~fs_allowin): latch br_pending <= 1 and br_target_r <= br_target.
  - br_pending clears on the next accepted fetch.
  - A new br_taken while br_pending = 1 is impossible (decode is stalled behind fs) and is not handled.
- Simultaneous events:
  - reset has priority over everything.
  - br_taken and accept in the same cycle: redirect directly, no pending latch.
- Reset mid-operation: every state element returns to its reset value on the next edge. An in-flight SRAM read is discarded (fs_valid = 0).

Optional Feature:
- Macro: FS_INST_BUF_EN.
- Defined:
  - A 32-bit skid buffer plus valid bit captures inst_sram_rdata in the first cycle that fs_valid & ~ds_allowin holds.
  - fs_inst is sourced from the buffer while it is valid.
  - The buffer is cleared on the fs→ds transfer or on reset.
  - The SRAM is not required to hold its output.
- Not defined:
  - No buffer. fs_inst = inst_sram_rdata directly.
  - Correctness relies on inst_sram_en = 0 during stalls, so the SRAM keeps its last output.

Decomposition:
- Shared package (mycpu.h):
  - BR_BUS_WD = 34, FS_TO_DS_BUS_WD = 64.
  - Field positions of br_bus and fs_to_ds_bus.
  - RESET_PC default.
- Sub-module: if_inst_buf is instantiated only under FS_INST_BUF_EN; it contains the skid register and its valid bit.
- All other logic is flat.

Test Plan:
- Release reset, ds_allowin = 1, no branches → inst_sram_addr sequence 0xbfc00000, 0xbfc00004, 0xbfc00008. fs_to_ds_valid rises 1 cycle after the first en. fs_to_ds_bus[31:0] follows the same sequence.
- Branch: br_bus = {0,1,0xbfc00100} for one cycle while fs_pc = 0xbfc00008 → decode receives 0xbfc00008 (delay slot), then 0xbfc00100.
- Stall: ds_allowin = 0 for 3 cycles with fs_pc = 0xbfc00010 → inst_sram_en = 0, fs_to_ds_bus stable at the inst at 0x…10. Fetch resumes at 0xbfc00014 afterwards. With FS_INST_BUF_EN, additionally drive garbage on rdata during the stall → decode still sees the original inst.
- Branch while stalled: br_taken with target 0xbfc00200 while ds_allowin = 0 → br_pending = 1. The first fetch after release addresses 0xbfc00200, then br_pending = 0.
- br_stall = 1 for 2 cycles → inst_sram_en = 0, bubbles to decode. Then br_taken = 1 to 0xbfc00040 with br_stall = 0 → next addr 0xbfc00040.
- Reset asserted mid-stream at fs_pc = 0xbfc0000c → next cycle fs_to_ds_valid = 0, br_pending = 0. The first fetch after release is 0xbfc00000.
